// File: rtl/snitch_vfpr_seq.sv
// snitch_vfpr_seq: turns whole-vector-register read/write commands into element-wise TCDM requests.
// Build option: define SNITCH_VFPR_SEQ_PERF_EN to add the stall_cycles_o counter output.
module snitch_vfpr_seq #(
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned NumVRegs       = 32,
    parameter int unsigned VLenMax        = 16,
    parameter int unsigned MaxOutstanding = 4,
    parameter type tcdm_req_t = struct packed {
        logic q_valid;
        struct packed {
            logic [AddrWidth-1:0]   addr;
            logic                   write;
            logic [3:0]             amo;
            logic [DataWidth-1:0]   data;
            logic [DataWidth/8-1:0] strb;
            logic                   user;
        } q;
    },
    parameter type tcdm_rsp_t = struct packed {
        logic q_ready;
        logic p_valid;
        struct packed {
            logic [DataWidth-1:0] data;
        } p;
    }
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic                          cmd_write_i,
    input  logic [$clog2(NumVRegs)-1:0]   cmd_vreg_i,
    input  logic [$clog2(VLenMax):0]      cmd_len_i,
    input  logic                          wdata_valid_i,
    output logic                          wdata_ready_o,
    input  logic [DataWidth-1:0]          wdata_i,
    output logic                          rdata_valid_o,
    input  logic                          rdata_ready_i,
    output logic [DataWidth-1:0]          rdata_o,
    output logic                          busy_o,
`ifdef SNITCH_VFPR_SEQ_PERF_EN
    output logic [31:0]                   stall_cycles_o,
`endif
    output tcdm_req_t                     vfpr_req_o,
    input  tcdm_rsp_t                     vfpr_rsp_i
);
    localparam int unsigned VW = $clog2(NumVRegs);
    localparam int unsigned IW = $clog2(VLenMax);
    localparam int unsigned LW = IW + 1;
    localparam int unsigned OW = $clog2(DataWidth / 8);
    localparam int unsigned CW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PW = $clog2(MaxOutstanding);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]           state_q, state_d;
    logic                 write_q;
    logic [VW-1:0]        vreg_q;
    logic [LW-1:0]        len_q, idx_q, len_clamp;
    logic [CW-1:0]        out_q, out_d, cnt_q;
    logic [PW-1:0]        wptr_q, rptr_q;
    logic [DataWidth-1:0] mem_q [MaxOutstanding];
    logic                 cmd_acc, credit, q_valid, acc, last, rsp, push, pop;

    assign cmd_ready_o   = state_q == IDLE;
    assign cmd_acc       = cmd_valid_i & cmd_ready_o;
    assign len_clamp     = (cmd_len_i > LW'(VLenMax)) ? LW'(VLenMax) : cmd_len_i;
    // Credits cover both in-flight requests and buffered responses, so the FIFO can never overflow.
    assign credit        = 32'(out_q) + 32'(cnt_q) < MaxOutstanding;
    assign q_valid       = (state_q == ISSUE) & credit & (~write_q | wdata_valid_i);
    assign acc           = q_valid & vfpr_rsp_i.q_ready;
    assign last          = idx_q == len_q - LW'(1);
    // Responses with nothing outstanding (e.g. stragglers around reset) are ignored.
    assign rsp           = vfpr_rsp_i.p_valid & (out_q != '0);
    assign push          = rsp & ~write_q;
    assign pop           = rdata_valid_o & rdata_ready_i;
    assign out_d         = out_q + CW'(acc) - CW'(rsp);
    assign wdata_ready_o = acc & write_q;
    assign rdata_valid_o = cnt_q != '0;
    assign rdata_o       = mem_q[rptr_q];
    assign busy_o        = (state_q != IDLE) | (out_q != '0) | rdata_valid_o;
    // DRAIN leaves on the edge that retires the last response, so cmd_ready_o rises the next cycle.
    assign state_d = (state_q == IDLE)  ? ((cmd_acc && cmd_len_i != '0) ? ISSUE : IDLE) :
                     (state_q == ISSUE) ? ((acc && last) ? DRAIN : ISSUE) :
                     ((out_d == '0) ? IDLE : DRAIN);

    // Request fields are zero whenever no request is presented.
    always_comb begin
        vfpr_req_o         = '0;
        vfpr_req_o.q_valid = q_valid;
        if (q_valid) begin
            vfpr_req_o.q.addr  = AddrWidth'({vreg_q, idx_q[IW-1:0], {OW{1'b0}}});
            vfpr_req_o.q.write = write_q;
            vfpr_req_o.q.data  = write_q ? wdata_i : '0;
            vfpr_req_o.q.strb  = '1;
        end
    end

    // Command sequencing state, element index and outstanding-request count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            vreg_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            if (cmd_acc) begin
                write_q <= cmd_write_i;
                vreg_q  <= cmd_vreg_i;
                len_q   <= len_clamp;
                idx_q   <= '0;
            end else if (acc) begin
                idx_q <= idx_q + LW'(1);
            end
        end
    end

    // Response FIFO pointers and occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop) rptr_q <= rptr_q + PW'(1);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    // Response FIFO storage; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= vfpr_rsp_i.p.data;
    end

    fifo_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && !pop && cnt_q == CW'(MaxOutstanding)));

`ifdef SNITCH_VFPR_SEQ_PERF_EN
    logic stall;
    assign stall = (state_q == ISSUE) & (~credit | (q_valid & ~vfpr_rsp_i.q_ready));
    // Saturating count of cycles the sequencer wanted to issue but could not.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) stall_cycles_o <= '0;
        else if (stall && stall_cycles_o != '1) stall_cycles_o <= stall_cycles_o + 32'd1;
    end
`endif
endmodule
